// File: rtl/reset_sequencer_if.sv
// Bundle of the sequencer's control inputs and reset/enable outputs.
// master: the block that requests sequencing and consumes resets/enables.
// slave:  the reset sequencer itself.
interface reset_sequencer_if #(
    parameter int N_CH  = 4,
    parameter int DIV_W = 8
);
    logic                    soft_req;
    logic [N_CH-1:0]         ch_hold;
    logic [N_CH*DIV_W-1:0]   div_ratio;
    logic [N_CH-1:0]         resetn_o;
    logic [N_CH-1:0]         ce_o;
    logic [1:0]              seq_state;
    logic                    done;

    modport master (
        output soft_req, ch_hold, div_ratio,
        input  resetn_o, ce_o, seq_state, done
    );

    modport slave (
        input  soft_req, ch_hold, div_ratio,
        output resetn_o, ce_o, seq_state, done
    );
endinterface

// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer: synchronises the release of the global
// reset, waits RESET_CYCLES, then releases N_CH active-low channel resets
// in index order STAGGER_CYCLES apart. Each released channel also gets a
// programmable divided clock-enable. A soft request in RUN re-runs the
// sequence from the counting phase without touching the synchroniser.
module reset_sequencer #(
    parameter int N_CH           = 4,
    parameter int RESET_CYCLES   = 32,
    parameter int STAGGER_CYCLES = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int CNT_W          = 16,
    parameter int DIV_W          = 8
) (
    input  logic              clk,
    input  logic              rst,
    reset_sequencer_if.slave  bus
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(N_CH - 1);

    typedef enum logic [1:0] {
        S_RESET   = 2'd0,
        S_COUNT   = 2'd1,
        S_RELEASE = 2'd2,
        S_RUN     = 2'd3
    } state_t;

    state_t                 state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [IDX_W-1:0]       idx_reg;
    logic [N_CH-1:0]        resetn_reg;
    logic                   done_reg;
    logic [N_CH-1:0]        ce_vec;

    // The first SYNC_STAGES-1 synchroniser flops live here; the state
    // register leaving S_RESET acts as the final stage, so the sequence
    // clock count starts on posedge SYNC_STAGES after rst falls.
    logic [SYNC_STAGES-2:0] sync_reg;
    logic                   rst_s;

    assign rst_s = sync_reg[SYNC_STAGES-2];

    // Reset-deassertion synchroniser: forced high by rst, shifts in zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= sync_reg << 1;
        end
    end

    // Sequencing FSM: count, staggered release, then run with per-channel hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_RESET;
            cnt_reg    <= '0;
            idx_reg    <= '0;
            resetn_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_RESET: begin
                    if (!rst_s) begin
                        state_reg <= S_COUNT;
                        cnt_reg   <= '0;
                    end
                end
                S_COUNT: begin
                    if (cnt_reg == RESET_LAST) begin
                        state_reg <= S_RELEASE;
                        cnt_reg   <= '0;
                        idx_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                S_RELEASE: begin
                    if (bus.ch_hold[idx_reg]) begin
                        // A held channel stalls the whole sequence and
                        // restarts its stagger interval once released.
                        cnt_reg <= '0;
                    end else if (cnt_reg == STAGGER_LAST) begin
                        resetn_reg[idx_reg] <= 1'b1;
                        cnt_reg             <= '0;
                        idx_reg             <= idx_reg + IDX_W'(1);
                        if (idx_reg == IDX_LAST) begin
                            state_reg <= S_RUN;
                            done_reg  <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    // A soft request takes priority over any hold change.
                    if (bus.soft_req) begin
                        resetn_reg <= '0;
                        done_reg   <= 1'b0;
                        state_reg  <= S_COUNT;
                        cnt_reg    <= '0;
                    end else begin
                        resetn_reg <= ~bus.ch_hold;
                    end
                end
                default: begin
                    state_reg <= S_RESET;
                end
            endcase
        end
    end

    // Per-channel clock-enable dividers, idle while the channel is in reset.
    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [DIV_W-1:0] dc_reg;
            logic [DIV_W-1:0] ratio;
            logic             ce_reg;

            assign ratio      = bus.div_ratio[gi*DIV_W +: DIV_W];
            assign ce_vec[gi] = ce_reg;

            // Fire when the count reaches or exceeds the ratio, so lowering
            // the ratio below the running count fires on the next clock.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dc_reg <= '0;
                    ce_reg <= 1'b0;
                end else if (!resetn_reg[gi]) begin
                    dc_reg <= '0;
                    ce_reg <= 1'b0;
                end else if (dc_reg >= ratio) begin
                    dc_reg <= '0;
                    ce_reg <= 1'b1;
                end else begin
                    dc_reg <= dc_reg + DIV_W'(1);
                    ce_reg <= 1'b0;
                end
            end
        end
    endgenerate

    assign bus.resetn_o  = resetn_reg;
    assign bus.ce_o      = ce_vec;
    assign bus.seq_state = state_reg;
    assign bus.done      = done_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer: directed scenarios with formula-derived
// expectations plus randomized traffic against a timestamp-based model.
module tb_reset_sequencer;

    localparam int N_CH  = 4;
    localparam int RC    = 32;
    localparam int SC    = 8;
    localparam int SS    = 2;
    localparam int CNT_W = 16;
    localparam int DIV_W = 8;
    localparam int OW    = 2*N_CH + 3;

    localparam logic [1:0] MD_RESET = 2'd0;
    localparam logic [1:0] MD_COUNT = 2'd1;
    localparam logic [1:0] MD_REL   = 2'd2;
    localparam logic [1:0] MD_RUN   = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    reset_sequencer_if #(.N_CH(N_CH), .DIV_W(DIV_W)) bus ();

    reset_sequencer #(
        .N_CH(N_CH), .RESET_CYCLES(RC), .STAGGER_CYCLES(SC),
        .SYNC_STAGES(SS), .CNT_W(CNT_W), .DIV_W(DIV_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Works with edge timestamps: m_t counts posedges since rst fell, the
    // next channel release is a deadline pushed out by holds, and each
    // enable fires when enough edges have passed since its last event.
    int              m_t;
    int              m_start;
    int              m_idx;
    int              m_due;
    int              m_last [N_CH];
    logic [1:0]      m_mode;
    logic [N_CH-1:0] m_resetn;
    logic [N_CH-1:0] m_ce;
    logic            m_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t      <= 0;
            m_start  <= 0;
            m_idx    <= 0;
            m_due    <= 0;
            m_mode   <= MD_RESET;
            m_resetn <= '0;
            m_ce     <= '0;
            m_done   <= 1'b0;
            for (int i = 0; i < N_CH; i++) m_last[i] <= 0;
        end else begin
            m_t <= m_t + 1;
            case (m_mode)
                MD_RESET: if (m_t + 1 == SS) begin
                    m_mode  <= MD_COUNT;
                    m_start <= m_t + 1;
                end
                MD_COUNT: if (m_t + 1 == m_start + RC) begin
                    m_mode <= MD_REL;
                    m_idx  <= 0;
                    m_due  <= m_t + 1 + SC;
                end
                MD_REL: begin
                    if (bus.ch_hold[m_idx]) begin
                        m_due <= m_t + 1 + SC;
                    end else if (m_t + 1 == m_due) begin
                        m_resetn[m_idx] <= 1'b1;
                        m_idx <= m_idx + 1;
                        m_due <= m_t + 1 + SC;
                        if (m_idx == N_CH - 1) begin
                            m_mode <= MD_RUN;
                            m_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (bus.soft_req) begin
                        m_resetn <= '0;
                        m_done   <= 1'b0;
                        m_mode   <= MD_COUNT;
                        m_start  <= m_t + 1;
                    end else begin
                        m_resetn <= ~bus.ch_hold;
                    end
                end
            endcase
            for (int i = 0; i < N_CH; i++) begin
                if (!m_resetn[i]) begin
                    m_ce[i]   <= 1'b0;
                    m_last[i] <= m_t + 1;
                end else if (m_t - m_last[i] >= int'(bus.div_ratio[i*DIV_W +: DIV_W])) begin
                    m_ce[i]   <= 1'b1;
                    m_last[i] <= m_t + 1;
                end else begin
                    m_ce[i] <= 1'b0;
                end
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.soft_req  = 1'b0;
        bus.ch_hold   = '0;
        bus.div_ratio = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++; if (bus.resetn_o !== '0) begin n_fail++; $display("FAIL reset_resetn: got %b expected 0", bus.resetn_o); end
        n_tests++; if (bus.ce_o !== '0) begin n_fail++; $display("FAIL reset_ce: got %b expected 0", bus.ce_o); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        n_tests++; if (bus.seq_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", bus.seq_state); end
    endtask

    task automatic test_sequence();
        int r [N_CH];
        int e;
        logic [N_CH-1:0] er, ec;
        logic ed;
        logic [1:0] es;
        bus.soft_req  = 1'b0;
        bus.ch_hold   = '0;
        bus.div_ratio = '0;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < N_CH; k++) r[k] = SS + RC + SC*(k+1);
        for (int c = 0; c < r[N_CH-1] + 12; c++) begin
            @(negedge clk);
            e = c + 1;
            for (int k = 0; k < N_CH; k++) begin
                er[k] = (e >= r[k]);
                ec[k] = (e >= r[k] + 1);
            end
            ed = (e >= r[N_CH-1]);
            es = (e < SS) ? 2'd0 : (e < SS + RC) ? 2'd1 : (e < r[N_CH-1]) ? 2'd2 : 2'd3;
            n_tests++; if (bus.resetn_o !== er) begin n_fail++; $display("FAIL seq_resetn edge %0d: got %b expected %b", e, bus.resetn_o, er); end
            n_tests++; if (bus.ce_o !== ec) begin n_fail++; $display("FAIL seq_ce edge %0d: got %b expected %b", e, bus.ce_o, ec); end
            n_tests++; if (bus.done !== ed) begin n_fail++; $display("FAIL seq_done edge %0d: got %b expected %b", e, bus.done, ed); end
            n_tests++; if (bus.seq_state !== es) begin n_fail++; $display("FAIL seq_state edge %0d: got %0d expected %0d", e, bus.seq_state, es); end
        end
        $display("[TB] sequence: releases at %0d %0d %0d %0d checked", r[0], r[1], r[2], r[3]);
    endtask

    task automatic test_run_hold();
        logic [OW-1:0] obs, exp;
        bus.div_ratio[3*DIV_W +: DIV_W] = 8'd2;
        repeat (4) @(negedge clk);
        bus.ch_hold[3] = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            n_tests++; if (bus.resetn_o[3] !== (c >= 4 ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL run_hold_resetn3 cycle %0d: got %b expected %b", c, bus.resetn_o[3], (c >= 4)); end
            n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL run_hold_done cycle %0d: got %b expected 1", c, bus.done); end
            obs = {bus.resetn_o, bus.ce_o, bus.done, bus.seq_state};
            exp = {m_resetn, m_ce, m_done, m_mode};
            n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL run_hold_model cycle %0d: got %h expected %h", c, obs, exp); end
            if (c == 3) bus.ch_hold[3] = 1'b0;
        end
        $display("[TB] run_hold: channel 3 held for 3 cycles");
    endtask

    task automatic test_divider();
        logic [OW-1:0] obs, exp;
        int highs;
        int w;
        bus.div_ratio[2*DIV_W +: DIV_W] = 8'd3;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            obs = {bus.resetn_o, bus.ce_o, bus.done, bus.seq_state};
            exp = {m_resetn, m_ce, m_done, m_mode};
            n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL div_model cycle %0d: got %h expected %h", c, obs, exp); end
        end
        highs = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (bus.ce_o[2] === 1'b1) highs++;
        end
        n_tests++; if (highs != 4) begin n_fail++; $display("FAIL div_period4: got %0d pulses expected 4 in 16 cycles", highs); end
        w = 0;
        while (m_ce[2] !== 1'b1 && w < 10) begin @(negedge clk); w++; end
        n_tests++; if (m_ce[2] !== 1'b1) begin n_fail++; $display("FAIL div_wait: no enable pulse within %0d cycles", w); end
        repeat (3) @(negedge clk);
        bus.div_ratio[2*DIV_W +: DIV_W] = 8'd1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_tests++; if (bus.ce_o[2] !== ((c % 2) == 0)) begin n_fail++; $display("FAIL div_change cycle %0d: got %b expected %b", c, bus.ce_o[2], ((c % 2) == 0)); end
        end
        $display("[TB] divider: ratio 3 then 1 on channel 2");
    endtask

    task automatic test_soft_req();
        logic [OW-1:0] obs, exp;
        int w;
        bus.ch_hold = '0;
        w = 0;
        while (bus.done !== 1'b1 && w < 200) begin @(negedge clk); w++; end
        n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL soft_pre_done: got %b expected 1", bus.done); end
        @(negedge clk);
        bus.soft_req = 1'b1;
        @(negedge clk);
        bus.soft_req = 1'b0;
        n_tests++; if (bus.resetn_o !== '0) begin n_fail++; $display("FAIL soft_resetn_at_P: got %b expected 0", bus.resetn_o); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL soft_done_at_P: got %b expected 0", bus.done); end
        n_tests++; if (bus.seq_state !== 2'd1) begin n_fail++; $display("FAIL soft_state_at_P: got %0d expected 1", bus.seq_state); end
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            n_tests++; if (bus.resetn_o[0] !== (c >= RC + SC ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL soft_resetn0 P+%0d: got %b expected %b", c, bus.resetn_o[0], (c >= RC + SC)); end
            n_tests++; if (bus.done !== (c >= RC + N_CH*SC ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL soft_done P+%0d: got %b expected %b", c, bus.done, (c >= RC + N_CH*SC)); end
            obs = {bus.resetn_o, bus.ce_o, bus.done, bus.seq_state};
            exp = {m_resetn, m_ce, m_done, m_mode};
            n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL soft_model P+%0d: got %h expected %h", c, obs, exp); end
        end
        $display("[TB] soft_req: sequence re-run checked");
    endtask

    task automatic test_hold_stall();
        logic [OW-1:0] obs, exp;
        int r0, drop, r1;
        bus.soft_req = 1'b0;
        bus.ch_hold  = 4'b0010;
        for (int k = 0; k < N_CH; k++) bus.div_ratio[k*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 5));
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        r0   = SS + RC + SC;
        drop = r0 + 20;
        r1   = drop + SC;
        for (int e = 1; e <= r1 + 2*SC + 10; e++) begin
            @(negedge clk);
            if (e > r0 && e < r1) begin
                n_tests++; if (bus.seq_state !== 2'd2) begin n_fail++; $display("FAIL stall_state edge %0d: got %0d expected 2", e, bus.seq_state); end
            end
            for (int k = 1; k < N_CH; k++) begin
                if (e == r1 + SC*(k-1) - 1 || e == r1 + SC*(k-1)) begin
                    n_tests++; if (bus.resetn_o[k] !== (e == r1 + SC*(k-1) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL stall_release%0d edge %0d: got %b expected %b", k, e, bus.resetn_o[k], (e == r1 + SC*(k-1))); end
                end
            end
            obs = {bus.resetn_o, bus.ce_o, bus.done, bus.seq_state};
            exp = {m_resetn, m_ce, m_done, m_mode};
            n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL stall_model edge %0d: got %h expected %h", e, obs, exp); end
            if (e == drop) bus.ch_hold[1] = 1'b0;
        end
        $display("[TB] hold_stall: channel 1 released at edge %0d", r1);
    endtask

    task automatic test_async_rst();
        bus.soft_req  = 1'b0;
        bus.ch_hold   = '0;
        bus.div_ratio = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (SS + RC + 2*SC + 3) @(negedge clk);
        n_tests++; if (bus.seq_state !== 2'd2) begin n_fail++; $display("FAIL async_pre_state: got %0d expected 2", bus.seq_state); end
        #1 rst = 1'b1;
        #1;
        n_tests++; if (bus.resetn_o !== '0) begin n_fail++; $display("FAIL async_resetn: got %b expected 0", bus.resetn_o); end
        n_tests++; if (bus.ce_o !== '0) begin n_fail++; $display("FAIL async_ce: got %b expected 0", bus.ce_o); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL async_done: got %b expected 0", bus.done); end
        n_tests++; if (bus.seq_state !== 2'd0) begin n_fail++; $display("FAIL async_state: got %0d expected 0", bus.seq_state); end
        $display("[TB] async_rst: asserted mid-release, rerunning sequence");
        test_sequence();
    endtask

    task automatic test_random();
        logic [OW-1:0] obs, exp;
        int rhold;
        rhold = 0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            obs = {bus.resetn_o, bus.ce_o, bus.done, bus.seq_state};
            exp = {m_resetn, m_ce, m_done, m_mode};
            n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL random_model cycle %0d: got %h expected %h", c, obs, exp); end
            bus.soft_req = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 9) == 0)
                bus.ch_hold = ($urandom_range(0, 2) == 0) ? N_CH'($urandom) : '0;
            if ($urandom_range(0, 19) == 0)
                for (int k = 0; k < N_CH; k++) bus.div_ratio[k*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 6));
            if (rhold > 0) begin
                rhold--;
                if (rhold == 0) rst = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                #1 rst = 1'b1;
                rhold = 2;
            end
        end
        rst = 1'b0;
        $display("[TB] random: 800 cycles compared against model");
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_run_hold();
        test_divider();
        test_soft_req();
        test_hold_stall();
        test_async_rst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
